// File: rtl/alu_pair_pkg.sv
// Shared types for the ALU operand pairer.
//   OPW          : operand / result width
//   pair_state_t : pairing FSM states
//   alu_out_t    : one captured ALU result (carry-out above the sum)
package alu_pair_pkg;

  localparam int unsigned OPW = 3;

  typedef enum logic [1:0] {
    WAIT_A,
    WAIT_B,
    ISSUE
  } pair_state_t;

  typedef struct packed {
    logic           cout;
    logic [OPW-1:0] result;
  } alu_out_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO holding captured ALU outputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full)
//   push_data  : entry to write
//   pop        : drop head entry (ignored when empty)
//   full/empty : occupancy flags
//   head       : head entry; forced to zero while empty
// DEPTH must be a power of two and at least 2.
module alu_result_fifo
  import alu_pair_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  alu_out_t push_data,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output alu_out_t head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // One extra pointer bit separates full from empty when the indices match.
  logic [PW-1:0] wr_q, rd_q;
  alu_out_t      mem_q [DEPTH];
  logic          push_en, pop_en;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_en) wr_q <= wr_q + PW'(1);
      if (pop_en)  rd_q <= rd_q + PW'(1);
    end
  end

  // Storage needs no reset: the empty gate below hides stale entries.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_q[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/alu_operand_pairer.sv
// Pairs consecutive input words into ALU operands a/b (cin taken with b),
// presents them to an external combinational ALU and queues its result.
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid/in_ready        : input word handshake
//   in_data, in_cin          : operand word; cin sampled only with the b word
//   alu_a, alu_b, alu_cin    : registered operands to the ALU
//   alu_result, alu_cout     : ALU outputs, captured while issuing
//   out_valid/out_ready      : result FIFO handshake
//   out_result, out_cout     : FIFO head entry
//   pair_count               : pairs pushed into the FIFO, wraps at 256
module alu_operand_pairer
  import alu_pair_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_data,
  input  logic           in_cin,
  output logic [OPW-1:0] alu_a,
  output logic [OPW-1:0] alu_b,
  output logic           alu_cin,
  input  logic [OPW-1:0] alu_result,
  input  logic           alu_cout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_result,
  output logic           out_cout,
  output logic [7:0]     pair_count
);

  pair_state_t    state_q, state_d;
  logic [OPW-1:0] a_q, a_d, b_q, b_d;
  logic           cin_q, cin_d;
  logic [7:0]     count_q, count_d;
  logic           fifo_push, fifo_full, fifo_empty;
  alu_out_t       fifo_in, fifo_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    fifo_push = 1'b0;
    case (state_q)
      WAIT_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b_d     = in_data;
          cin_d   = in_cin;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Full is the pre-pop flag, so a same-cycle pop only frees the slot
        // for the next cycle's retry.
        if (!fifo_full) begin
          fifo_push = 1'b1;
          count_d   = count_q + 8'd1;
          state_d   = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_cin = cin_q;

  assign fifo_in.cout   = alu_cout;
  assign fifo_in.result = alu_result;

  alu_result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(fifo_in),
    .pop      (out_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign out_valid  = !fifo_empty;
  assign out_result = fifo_head.result;
  assign out_cout   = fifo_head.cout;
  assign pair_count = count_q;

endmodule
